// File: rtl/spi_rx_fifo_if.sv
// Receive-buffer port bundle: receiver-side push/throttle, consumer-side valid/ready, status.
// The slave modport is the FIFO's view; the master modport is the environment's view.
interface spi_rx_fifo_if #(
    parameter int DEPTH = 8
) ();
    localparam int AW = $clog2(DEPTH);

    logic          clr_i;
    logic [31:0]   rx_data_i;
    logic          rx_data_vld_i;
    logic          rx_data_rdy_o;
    logic [15:0]   rx_length_i;
    logic          rx_length_updt_i;
    logic [31:0]   data_o;
    logic          data_vld_o;
    logic          data_rdy_i;
    logic [AW:0]   level_o;
    logic          full_o;
    logic          empty_o;
    logic          overflow_o;

    modport slave (
        input  clr_i,
        input  rx_data_i,
        input  rx_data_vld_i,
        output rx_data_rdy_o,
        input  rx_length_i,
        input  rx_length_updt_i,
        output data_o,
        output data_vld_o,
        input  data_rdy_i,
        output level_o,
        output full_o,
        output empty_o,
        output overflow_o
    );

    modport master (
        output clr_i,
        output rx_data_i,
        output rx_data_vld_i,
        input  rx_data_rdy_o,
        output rx_length_i,
        output rx_length_updt_i,
        input  data_o,
        input  data_vld_o,
        output data_rdy_i,
        input  level_o,
        input  full_o,
        input  empty_o,
        input  overflow_o
    );
endinterface

// File: rtl/spi_rx_fifo.sv
// SPI receive word FIFO (first-word-fall-through) with receiver throttling and sticky overflow.
// Define SPI_RX_FIFO_MASK_EN to enable the bit budget that zero-masks a final partial word.
module spi_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    spi_rx_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEVEL_THRESH = (AW+1)'(DEPTH - 1);

    logic            vld_q, vld_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     level_q, level_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     mem_q [DEPTH];

    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            wr_en;
    logic [31:0]     wr_data;

    // The receiver idles high, so only a rising edge marks a freshly completed word.
    assign push  = bus.rx_data_vld_i && !vld_q;
    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);
    assign pop   = !empty && bus.data_rdy_i;
    assign wr_en = push && (!full || pop);

`ifdef SPI_RX_FIFO_MASK_EN
    logic [15:0]     bits_left_q, bits_left_d;

    always_comb begin
        wr_data     = bus.rx_data_i;
        bits_left_d = bits_left_q;
        if (push) begin
            if (bits_left_q >= 16'd32) begin
                bits_left_d = bits_left_q - 16'd32;
            end else if (bits_left_q != 16'd0) begin
                wr_data     = bus.rx_data_i & ((32'h1 << bits_left_q[4:0]) - 32'h1);
                bits_left_d = '0;
            end
        end
        // A length load overrides the push's decrement; the push was already masked above.
        if (bus.rx_length_updt_i) begin
            bits_left_d = bus.rx_length_i;
        end
        if (bus.clr_i) begin
            bits_left_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bits_left_q <= '0;
        end else begin
            bits_left_q <= bits_left_d;
        end
    end
`else
    assign wr_data = bus.rx_data_i;
`endif

    always_comb begin
        vld_d      = vld_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (bus.clr_i) begin
            vld_d      = 1'b1;
            wptr_d     = '0;
            rptr_d     = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            vld_d = bus.rx_data_vld_i;
            if (wr_en) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push && !wr_en) begin
                overflow_d = 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q      <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: data_o is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (wr_en && !bus.clr_i) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    assign bus.data_o        = empty ? 32'h0 : mem_q[rptr_q];
    assign bus.data_vld_o    = !empty;
    assign bus.level_o       = level_q;
    assign bus.full_o        = full;
    assign bus.empty_o       = empty;
    assign bus.overflow_o    = overflow_q;
    // One slot stays reserved for the word the receiver is already shifting in.
    assign bus.rx_data_rdy_o = (level_q < LEVEL_THRESH);

    property p_level_bounded;
        @(posedge clk_i) disable iff (!rst_n_i) level_q <= LEVEL_FULL;
    endproperty
    assert property (p_level_bounded);

    property p_ptr_gap;
        @(posedge clk_i) disable iff (!rst_n_i)
            (level_q != LEVEL_FULL) |-> (AW'(wptr_q - rptr_q) == level_q[AW-1:0]);
    endproperty
    assert property (p_ptr_gap);

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Self-checking bench for spi_rx_fifo: directed scenarios plus random traffic against a queue model.
// Expected values follow SPI_RX_FIFO_MASK_EN the same way the design build does.
module tb_spi_rx_fifo;
    localparam int DEPTH = 8;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;

    spi_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    spi_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int          check_count = 0;
    int          error_count = 0;
    logic [31:0] model_q [$];
    bit          model_ovf;
    int          model_budget;
    bit          model_prev;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_ovf    = 1'b0;
        model_budget = 0;
        model_prev   = 1'b1;
    endtask

    task automatic checkAll();
        int sz;
        sz = model_q.size();
        checkOutput("level", 32'(bus.level_o), 32'(sz));
        checkOutput("data_vld", 32'(bus.data_vld_o), 32'(sz != 0));
        checkOutput("data", bus.data_o, (sz != 0) ? model_q[0] : 32'h0);
        checkOutput("full", 32'(bus.full_o), 32'(sz == DEPTH));
        checkOutput("empty", 32'(bus.empty_o), 32'(sz == 0));
        checkOutput("overflow", 32'(bus.overflow_o), 32'(model_ovf));
        checkOutput("rx_rdy", 32'(bus.rx_data_rdy_o), 32'(sz < DEPTH - 1));
    endtask

    // Drives one cycle of inputs, advances the model by the rules, then checks after the edge.
    task automatic applyStimulus(input logic vld, input logic [31:0] data, input logic rdy,
                                 input logic updt, input logic [15:0] len, input logic clr);
        bit          push;
        bit          pop;
        logic [31:0] word;
        bus.rx_data_vld_i    = vld;
        bus.rx_data_i        = data;
        bus.data_rdy_i       = rdy;
        bus.rx_length_updt_i = updt;
        bus.rx_length_i      = len;
        bus.clr_i            = clr;
        push = vld && !model_prev;
        pop  = (model_q.size() != 0) && rdy;
        if (clr) begin
            modelReset();
        end else begin
            word = data;
`ifdef SPI_RX_FIFO_MASK_EN
            if (push) begin
                if (model_budget >= 32) begin
                    model_budget = model_budget - 32;
                end else if (model_budget > 0) begin
                    word = data & 32'((64'd1 << model_budget) - 64'd1);
                    model_budget = 0;
                end
            end
            if (updt) model_budget = int'(len);
`endif
            if (pop) void'(model_q.pop_front());
            if (push) begin
                if (model_q.size() < DEPTH) model_q.push_back(word);
                else model_ovf = 1'b1;
            end
            model_prev = vld;
        end
        @(posedge clk_i);
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic pushWord(input logic [31:0] data, input logic rdy);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'd0, 1'b0);
        applyStimulus(1'b1, data, rdy, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic popWord();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic clearFifo();
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 16'd0, 1'b1);
    endtask

    initial begin
        bus.clr_i            = 1'b0;
        bus.rx_data_i        = 32'h0;
        bus.rx_data_vld_i    = 1'b1;
        bus.rx_length_i      = 16'd0;
        bus.rx_length_updt_i = 1'b0;
        bus.data_rdy_i       = 1'b0;
        modelReset();

        #12;
        checkOutput("rst_level", 32'(bus.level_o), 32'd0);
        checkOutput("rst_data_vld", 32'(bus.data_vld_o), 32'd0);
        checkOutput("rst_empty", 32'(bus.empty_o), 32'd1);
        checkOutput("rst_full", 32'(bus.full_o), 32'd0);
        checkOutput("rst_overflow", 32'(bus.overflow_o), 32'd0);
        checkOutput("rst_rx_rdy", 32'(bus.rx_data_rdy_o), 32'd1);
        checkOutput("rst_data", bus.data_o, 32'h0);
        rst_n_i = 1'b1;

        // Idle-high receiver after reset must not push; then one clean pulse pushes once.
        idle(10);
        checkOutput("idle_level", 32'(bus.level_o), 32'd0);
        pushWord(32'hA5A5_0001, 1'b0);
        checkOutput("pulse_vld", 32'(bus.data_vld_o), 32'd1);
        checkOutput("pulse_level", 32'(bus.level_o), 32'd1);
        popWord();

        // Length-80 transfer: third word is partial under masking.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 16'd80, 1'b0);
        pushWord(32'hDEAD_BEEF, 1'b0);
        pushWord(32'h1234_5678, 1'b0);
        pushWord(32'hFFFF_FFFF, 1'b0);
        checkOutput("len80_w0", bus.data_o, 32'hDEAD_BEEF);
        popWord();
        checkOutput("len80_w1", bus.data_o, 32'h1234_5678);
        popWord();
`ifdef SPI_RX_FIFO_MASK_EN
        checkOutput("len80_w2", bus.data_o, 32'h0000_FFFF);
`else
        checkOutput("len80_w2", bus.data_o, 32'hFFFF_FFFF);
`endif
        popWord();

        // Fill without pops, watch throttle, full and overflow, then flush.
        clearFifo();
        for (int i = 0; i < DEPTH; i++) begin
            pushWord(32'h100 + 32'(i), 1'b0);
            if (i == DEPTH - 2) checkOutput("rdy_drop", 32'(bus.rx_data_rdy_o), 32'd0);
        end
        checkOutput("fill_full", 32'(bus.full_o), 32'd1);
        pushWord(32'hBAD0_0009, 1'b0);
        checkOutput("ovf_set", 32'(bus.overflow_o), 32'd1);
        checkOutput("ovf_level", 32'(bus.level_o), 32'(DEPTH));
        clearFifo();
        checkOutput("clr_level", 32'(bus.level_o), 32'd0);
        checkOutput("clr_ovf", 32'(bus.overflow_o), 32'd0);
        checkOutput("clr_empty", 32'(bus.empty_o), 32'd1);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) pushWord(32'h200 + 32'(i), 1'b0);
        pushWord(32'hCAFE_F00D, 1'b1);
        checkOutput("pp_ovf", 32'(bus.overflow_o), 32'd0);
        checkOutput("pp_level", 32'(bus.level_o), 32'(DEPTH));
        for (int i = 0; i < DEPTH - 1; i++) popWord();
        checkOutput("pp_word", bus.data_o, 32'hCAFE_F00D);
        popWord();

        // Wrap-around: twenty push/pop pairs.
        clearFifo();
        for (int i = 1; i <= 20; i++) begin
            pushWord(32'(i), 1'b0);
            checkOutput("wrap_data", bus.data_o, 32'(i));
            popWord();
        end

        // Length load coinciding with a push masks that push with the old (zero) budget.
        clearFifo();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'd0, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 16'd40, 1'b0);
        pushWord(32'hFFFF_FFFF, 1'b0);
        pushWord(32'hFFFF_FFFF, 1'b0);
        checkOutput("len40_w0", bus.data_o, 32'hFFFF_FFFF);
        popWord();
        checkOutput("len40_w1", bus.data_o, 32'hFFFF_FFFF);
        popWord();
`ifdef SPI_RX_FIFO_MASK_EN
        checkOutput("len40_w2", bus.data_o, 32'h0000_00FF);
`else
        checkOutput("len40_w2", bus.data_o, 32'hFFFF_FFFF);
`endif
        popWord();

        // Random traffic.
        clearFifo();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 9) == 0), 16'($urandom_range(0, 100)),
                          1'($urandom_range(0, 59) == 0));
        end

        // Asynchronous reset in the middle of a cycle with words held.
        clearFifo();
        pushWord(32'h1111_1111, 1'b0);
        pushWord(32'h2222_2222, 1'b0);
        pushWord(32'h3333_3333, 1'b0);
        #2;
        rst_n_i = 1'b0;
        #1;
        checkOutput("arst_level", 32'(bus.level_o), 32'd0);
        checkOutput("arst_empty", 32'(bus.empty_o), 32'd1);
        checkOutput("arst_data", bus.data_o, 32'h0);
        checkOutput("arst_rx_rdy", 32'(bus.rx_data_rdy_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        modelReset();
        idle(3);
        pushWord(32'h4444_4444, 1'b0);
        popWord();

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end
endmodule
